// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and the NOP
// instruction the PC presents while a fetch bubble drains.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    FLUSH,
    HALT,
    IRQ_ENTRY
  } seq_state_e;

  localparam logic [15:0] NOP_INSTRUCTION = 16'hFFFF;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack: storage array plus an entry counter.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (clears the counter only)
//   push, pop, din  write / remove one entry; push when full and pop when
//                   empty are ignored
//   top             most recently pushed entry (undefined when empty)
//   depth           entry count, 0..DEPTH
//   full, empty     count at DEPTH / count at zero
module return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt_q;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign depth = cnt_q;
  assign top   = mem[PTR_W'(cnt_q - CNT_W'(1))];

  // Entry counter; saturates at DEPTH because a push while full is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage is not reset; the counter alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push && !full) begin
      mem[PTR_W'(cnt_q)] <= din;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: chooses increment / load / hold for the program counter
// each cycle, owns the CALL/RET return stack and inserts the one-cycle
// fetch bubble (FLUSH) after every load.
// Optional feature macro: FETCH_SEQ_IRQ_EN (adds i_irq, o_irq_ack, IRQ_VECTOR).
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_pc_addr            address following the executing instruction
//   i_stall              hold the PC
//   i_jump/i_call/i_ret  branch, call (push + branch), return (pop + branch)
//   i_halt               stop fetching until reset
//   i_target             branch / call target
//   o_pc_inc/o_pc_load/o_pc_addr  PC controls (combinational, PC registers them)
//   o_halted             sequencer is halted
//   o_stack_depth        return-stack entry count
//   o_stack_err          sticky overflow / underflow flag
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
`ifdef FETCH_SEQ_IRQ_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1}
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
`ifdef FETCH_SEQ_IRQ_EN
  input  logic                         i_irq,
  output logic                         o_irq_ack,
`endif
  input  logic [ADDR_WIDTH-1:0]        i_pc_addr,
  input  logic                         i_stall,
  input  logic                         i_jump,
  input  logic                         i_call,
  input  logic                         i_ret,
  input  logic                         i_halt,
  input  logic [ADDR_WIDTH-1:0]        i_target,
  output logic                         o_pc_inc,
  output logic                         o_pc_load,
  output logic [ADDR_WIDTH-1:0]        o_pc_addr,
  output logic                         o_halted,
  output logic [$clog2(STACK_DEPTH):0] o_stack_depth,
  output logic                         o_stack_err
);

  seq_state_e              state_q, state_d;
  logic                    err_q, err_d;
  logic                    push_c, pop_c;
  logic                    pc_inc_c, pc_load_c;
  logic [ADDR_WIDTH-1:0]   pc_addr_c;
  logic [ADDR_WIDTH-1:0]   stk_top;
  logic                    stk_full, stk_empty;
`ifdef FETCH_SEQ_IRQ_EN
  logic                    irq_mask_q, irq_mask_d;
`endif

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_c),
    .pop     (pop_c),
    .din     (i_pc_addr),
    .top     (stk_top),
    .depth   (o_stack_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // State and sticky error registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef FETCH_SEQ_IRQ_EN
  // IRQ mask: set when an interrupt is taken, cleared by the next successful pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_mask_q <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
    end
  end
`endif

  // Next-state, stack strobes and PC controls.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    pc_inc_c  = 1'b0;
    pc_load_c = 1'b0;
    pc_addr_c = '0;
`ifdef FETCH_SEQ_IRQ_EN
    irq_mask_d = irq_mask_q;
`endif
    unique case (state_q)
      BOOT: begin
        pc_load_c = 1'b1;
        pc_addr_c = RESET_VECTOR;
        state_d   = FLUSH;
      end
      RUN: begin
`ifdef FETCH_SEQ_IRQ_EN
        // An unmasked IRQ with no room to save the return address is refused.
        if (!i_halt && !i_ret && i_irq && !irq_mask_q && stk_full) begin
          err_d = 1'b1;
        end
`endif
        if (i_halt) begin
          state_d = HALT;
        end else if (i_ret) begin
          if (!stk_empty) begin
            pop_c     = 1'b1;
            pc_load_c = 1'b1;
            pc_addr_c = stk_top;
            state_d   = FLUSH;
`ifdef FETCH_SEQ_IRQ_EN
            irq_mask_d = 1'b0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
`ifdef FETCH_SEQ_IRQ_EN
        else if (i_irq && !irq_mask_q && !stk_full) begin
          push_c     = 1'b1;
          pc_load_c  = 1'b1;
          pc_addr_c  = IRQ_VECTOR;
          irq_mask_d = 1'b1;
          state_d    = IRQ_ENTRY;
        end
`endif
        else if (i_call) begin
          // Overflow drops the push but still takes the branch.
          if (stk_full) begin
            err_d = 1'b1;
          end else begin
            push_c = 1'b1;
          end
          pc_load_c = 1'b1;
          pc_addr_c = i_target;
          state_d   = FLUSH;
        end else if (i_jump) begin
          pc_load_c = 1'b1;
          pc_addr_c = i_target;
          state_d   = FLUSH;
        end else if (!i_stall) begin
          pc_inc_c = 1'b1;
        end
      end
      FLUSH: begin
        // Bubble cycle: only stall is honoured.
        if (!i_stall) begin
          pc_inc_c = 1'b1;
          state_d  = RUN;
        end
      end
`ifdef FETCH_SEQ_IRQ_EN
      IRQ_ENTRY: begin
        // Bubble cycle that also carries the one-shot acknowledge.
        if (i_stall) begin
          state_d = FLUSH;
        end else begin
          pc_inc_c = 1'b1;
          state_d  = RUN;
        end
      end
`endif
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // PC controls are held quiet while reset is asserted (state already reads BOOT).
  assign o_pc_inc    = pc_inc_c & i_rst_n;
  assign o_pc_load   = pc_load_c & i_rst_n;
  assign o_pc_addr   = i_rst_n ? pc_addr_c : '0;
  assign o_halted    = (state_q == HALT);
  assign o_stack_err = err_q;
`ifdef FETCH_SEQ_IRQ_EN
  assign o_irq_ack   = (state_q == IRQ_ENTRY);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// behavioural model (mode + queue-based stack + PC model).
module tb_fetch_sequencer;

  localparam int unsigned SD = 8;
  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc_addr, target;
  logic       stall, jump, call, ret, halt;
  logic       o_inc, o_load, o_halted, o_err;
  logic [7:0] o_addr;
  logic [3:0] o_depth;
`ifdef FETCH_SEQ_IRQ_EN
  logic       irq = 1'b0;
  logic       irq_ack;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH   (8),
    .STACK_DEPTH  (SD),
    .RESET_VECTOR (8'h00)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
`ifdef FETCH_SEQ_IRQ_EN
    .i_irq         (irq),
    .o_irq_ack     (irq_ack),
`endif
    .i_pc_addr     (pc_addr),
    .i_stall       (stall),
    .i_jump        (jump),
    .i_call        (call),
    .i_ret         (ret),
    .i_halt        (halt),
    .i_target      (target),
    .o_pc_inc      (o_inc),
    .o_pc_load     (o_load),
    .o_pc_addr     (o_addr),
    .o_halted      (o_halted),
    .o_stack_depth (o_depth),
    .o_stack_err   (o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int         m_mode;
  logic [7:0] m_stk[$];
  bit         m_err;
  logic [7:0] pc;

  // Model predictions for the current cycle
  bit         e_inc, e_load, e_halted, e_err;
  logic [7:0] e_addr;
  int         e_depth;
  int         n_mode;
  bit         n_push, n_pop, n_err;

  // Sampled DUT outputs for the current cycle
  logic       s_inc, s_load, s_halted, s_err;
  logic [7:0] s_addr;
  logic [3:0] s_depth;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    e_inc = 0; e_load = 0; e_addr = 8'h00;
    e_halted = (m_mode == M_HALT);
    e_depth  = m_stk.size();
    e_err    = m_err;
    n_mode = m_mode; n_push = 0; n_pop = 0; n_err = m_err;
    case (m_mode)
      M_BOOT: begin e_load = 1; e_addr = 8'h00; n_mode = M_FLUSH; end
      M_RUN: begin
        if (halt) n_mode = M_HALT;
        else if (ret) begin
          if (m_stk.size() > 0) begin
            e_load = 1; e_addr = m_stk[$]; n_pop = 1; n_mode = M_FLUSH;
          end else begin
            n_err = 1; n_mode = M_HALT;
          end
        end else if (call) begin
          if (m_stk.size() < SD) n_push = 1; else n_err = 1;
          e_load = 1; e_addr = target; n_mode = M_FLUSH;
        end else if (jump) begin
          e_load = 1; e_addr = target; n_mode = M_FLUSH;
        end else if (!stall) e_inc = 1;
      end
      M_FLUSH: if (!stall) begin e_inc = 1; n_mode = M_RUN; end
      default: ;
    endcase
  endfunction

  function automatic void model_commit();
    if (n_push) m_stk.push_back(pc);
    if (n_pop) void'(m_stk.pop_back());
    m_err  = n_err;
    m_mode = n_mode;
    if (e_load) pc = e_addr;
    else if (e_inc) pc = pc + 8'd1;
  endfunction

  // One clock: present PC, sample/compare at negedge+1, commit model at posedge.
  task automatic cycle();
    @(negedge clk);
    pc_addr = pc;
    #1;
    model_eval();
    s_inc = o_inc; s_load = o_load; s_addr = o_addr;
    s_halted = o_halted; s_depth = o_depth; s_err = o_err;
    check("inc", 32'(s_inc), 32'(e_inc));
    check("load", 32'(s_load), 32'(e_load));
    if (e_load) check("addr", 32'(s_addr), 32'(e_addr));
    check("halted", 32'(s_halted), 32'(e_halted));
    check("depth", 32'(s_depth), 32'(e_depth));
    check("err", 32'(s_err), 32'(e_err));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; jump = 0; call = 0; ret = 0; halt = 0; target = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_inc", 32'(o_inc), 32'd0);
    check("rst_load", 32'(o_load), 32'd0);
    check("rst_halted", 32'(o_halted), 32'd0);
    check("rst_depth", 32'(o_depth), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    m_mode = M_BOOT;
    m_stk.delete();
    m_err = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    rst_n = 1'b0;
    pc = 8'h00;
    pc_addr = 8'h00;
    clear_inputs();
    m_mode = M_BOOT;
    m_err = 0;

    // Reset release: boot load, bubble, then steady increment
    do_reset();
    cycle(); check("t1_load", 32'(s_load), 32'd1); check("t1_addr", 32'(s_addr), 32'h00);
    cycle(); check("t1_flush_inc", 32'(s_inc), 32'd1); check("t1_flush_load", 32'(s_load), 32'd0);
    cycle(); check("t1_run_inc", 32'(s_inc), 32'd1);
    cycle(); check("t1_run_inc2", 32'(s_inc), 32'd1);

    // Jump, repeated request in the bubble is ignored
    jump = 1; target = 8'h40;
    cycle(); check("t2_load", 32'(s_load), 32'd1); check("t2_addr", 32'(s_addr), 32'h40);
    cycle(); check("t2_bubble_load", 32'(s_load), 32'd0); check("t2_bubble_inc", 32'(s_inc), 32'd1);
    jump = 0;
    cycle(); check("t2_resume", 32'(s_inc), 32'd1);

    // Call then return
    pc = 8'h11; call = 1; target = 8'h80;
    cycle(); check("t3_call_addr", 32'(s_addr), 32'h80); check("t3_call_load", 32'(s_load), 32'd1);
    call = 0;
    cycle(); check("t3_depth1", 32'(s_depth), 32'd1);
    ret = 1;
    cycle(); check("t3_ret_addr", 32'(s_addr), 32'h11); check("t3_ret_load", 32'(s_load), 32'd1);
    ret = 0;
    cycle(); check("t3_depth0", 32'(s_depth), 32'd0);

    // Nine calls into an eight-entry stack, then drain and underflow
    for (int i = 0; i < 9; i++) begin
      call = 1; target = 8'h90 + 8'(i);
      cycle();
      if (i == 8) begin
        check("t4_ovf_load", 32'(s_load), 32'd1);
        check("t4_ovf_addr", 32'(s_addr), 32'h98);
        check("t4_ovf_depth", 32'(s_depth), 32'd8);
      end
      call = 0;
      cycle();
    end
    check("t4_err", 32'(s_err), 32'd1);
    check("t4_depth_sat", 32'(s_depth), 32'd8);
    for (int i = 0; i < 8; i++) begin
      ret = 1;
      cycle();
      if (i == 0) check("t4_first_ret", 32'(s_addr), 32'h97);
      ret = 0;
      cycle();
    end
    check("t4_empty", 32'(s_depth), 32'd0);
    ret = 1;
    cycle(); check("t4_unf_load", 32'(s_load), 32'd0);
    ret = 0;
    cycle(); check("t4_halted", 32'(s_halted), 32'd1);

    // Stall in RUN and in FLUSH, then halt under stall
    do_reset();
    cycle(); cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("t5_run_hold", 32'({s_inc, s_load}), 32'd0);
    end
    stall = 0;
    cycle(); check("t5_run_resume", 32'(s_inc), 32'd1);
    jump = 1; target = 8'h55;
    cycle();
    jump = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("t5_flush_hold", 32'({s_inc, s_load}), 32'd0);
    end
    stall = 0;
    cycle(); check("t5_flush_resume", 32'(s_inc), 32'd1);
    stall = 1; halt = 1;
    cycle(); check("t5_halt_ctl", 32'({s_inc, s_load}), 32'd0);
    clear_inputs();
    cycle(); check("t5_halted", 32'(s_halted), 32'd1);

    // Randomized run with phases biased toward overflow, underflow, or mix
    do_reset();
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      int phase, pcall, pret;
      phase = (i / 150) % 3;
      pcall = (phase == 0) ? 45 : (phase == 1) ? 5 : 20;
      pret  = (phase == 0) ? 5 : (phase == 1) ? 45 : 20;
      halt   = ($urandom_range(0, 299) == 0);
      ret    = ($urandom_range(0, 99) < pret);
      call   = ($urandom_range(0, 99) < pcall);
      jump   = ($urandom_range(0, 99) < 15);
      stall  = ($urandom_range(0, 99) < 20);
      target = 8'($urandom_range(0, 255));
      cycle();
      halt_cycles = (m_mode == M_HALT) ? halt_cycles + 1 : 0;
      if (halt_cycles > 3 || $urandom_range(0, 499) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
